// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/bubble/flush control and a retire counter.
// Optional HI/LO channel enabled by defining MEM_WB_HILO_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_llbit_we,
    input  logic              mem_llbit_val,
    output logic [REG_AW-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_llbit_we,
    output logic              wb_llbit_val,
    output logic [CNT_W-1:0]  retire_cnt
);

    // Per-cycle action, decoded in strict priority order.
    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_ADVANCE
    } action_e;

    action_e action;

    always_comb begin
        action = ACT_ADVANCE;
        if (rst)
            action = ACT_RESET;
        else if (flush)
            action = ACT_FLUSH;
        else if (stall_mem && !stall_wb)
            action = ACT_BUBBLE;
        else if (stall_mem)
            action = ACT_HOLD;
    end

    logic [REG_AW-1:0] wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              llbit_we_q, llbit_we_d;
    logic              llbit_val_q, llbit_val_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hilo_write;

`ifdef MEM_WB_HILO_EN
    logic              whilo_q, whilo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    assign hilo_write = mem_whilo;

    always_comb begin
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (action)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                whilo_d = 1'b0;
                hi_d    = '0;
                lo_d    = '0;
            end
            ACT_ADVANCE: begin
                whilo_d = mem_whilo;
                hi_d    = mem_hi;
                lo_d    = mem_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        whilo_q <= whilo_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
    end

    assign wb_whilo = whilo_q;
    assign wb_hi    = hi_q;
    assign wb_lo    = lo_q;
`else
    // HI/LO inputs are accepted but have no effect in this build.
    logic unused_hilo;
    assign unused_hilo = ^{mem_whilo, mem_hi, mem_lo};
    assign hilo_write  = 1'b0;
    assign wb_whilo    = 1'b0;
    assign wb_hi       = '0;
    assign wb_lo       = '0;
`endif

    always_comb begin
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        wdata_d     = wdata_q;
        llbit_we_d  = llbit_we_q;
        llbit_val_d = llbit_val_q;
        cnt_d       = cnt_q;
        case (action)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                wd_d        = '0;
                wreg_d      = 1'b0;
                wdata_d     = '0;
                llbit_we_d  = 1'b0;
                llbit_val_d = 1'b0;
                if (action == ACT_RESET)
                    cnt_d = '0;
            end
            ACT_ADVANCE: begin
                wd_d        = mem_wd;
                wreg_d      = mem_wreg;
                wdata_d     = mem_wdata;
                llbit_we_d  = mem_llbit_we;
                llbit_val_d = mem_llbit_val;
                // Counter wraps naturally at 2^CNT_W.
                if (mem_wreg || hilo_write)
                    cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        wd_q        <= wd_d;
        wreg_q      <= wreg_d;
        wdata_q     <= wdata_d;
        llbit_we_q  <= llbit_we_d;
        llbit_val_q <= llbit_val_d;
        cnt_q       <= cnt_d;
    end

    assign wb_wd        = wd_q;
    assign wb_wreg      = wreg_q;
    assign wb_wdata     = wdata_q;
    assign wb_llbit_we  = llbit_we_q;
    assign wb_llbit_val = llbit_val_q;
    assign retire_cnt   = cnt_q;

endmodule
